// File: rtl/mac_row_ctrl.sv
// mac_row_ctrl: sequencer for one mac_row. Loads weights over a valid/ready
// stream as weight-load instructions, streams activations as execute
// instructions, flushes the row with zero activations and pulses done.
// Optional feature: define MAC_ROW_CTRL_STATS_EN to add the stall_cnt port.
module mac_row_ctrl #(
    parameter int bw     = 2,
    parameter int col    = 4,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [len_bw-1:0] act_len,
    input  logic [2*bw-1:0]   w_data,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [2*bw-1:0]   a_data,
    input  logic              a_valid,
    output logic              a_ready,
    output logic [bw-1:0]     in_w0,
    output logic [bw-1:0]     in_w1,
    output logic [2:0]        inst_w,
    output logic              busy,
    output logic              done
`ifdef MAC_ROW_CTRL_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int                DCW      = $clog2(col) + 1;
    localparam logic [len_bw-1:0] W_TGT_M0 = len_bw'(2 * col);
    localparam logic [len_bw-1:0] W_TGT_M1 = len_bw'(col);
    localparam logic [len_bw-1:0] ONE      = len_bw'(1);
    localparam logic [DCW-1:0]    D_LAST   = DCW'(col - 1);

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic                mode_r;
    logic [len_bw-1:0]   len_r;
    logic [len_bw-1:0]   w_cnt;
    logic [len_bw-1:0]   a_cnt;
    logic [DCW-1:0]      d_cnt;
    logic [len_bw-1:0]   w_tgt;
    logic                beat_acc;
    logic [2:0]          inst_p0;
    logic [2*bw-1:0]     row_p0;

`ifdef MAC_ROW_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // 4-bit weights use one beat per column, 2-bit weights need two
    assign w_tgt = mode_r ? W_TGT_M1 : W_TGT_M0;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, stream readiness and the instruction/data for the next cycle
    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        beat_acc  = 1'b0;
        inst_p0   = 3'b000;
        row_p0    = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                w_ready = 1'b1;
                inst_p0 = {mode_r, 2'b00};
                if (w_valid) begin
                    beat_acc = 1'b1;
                    inst_p0  = {mode_r, 2'b01};
                    row_p0   = w_data;
                    if (w_cnt + ONE == w_tgt)
                        state_nxt = (len_r == '0) ? DRAIN : EXEC;
                end
            end
            EXEC: begin
                a_ready = 1'b1;
                inst_p0 = {mode_r, 2'b00};
                if (a_valid) begin
                    beat_acc = 1'b1;
                    inst_p0  = {mode_r, 2'b10};
                    row_p0   = a_data;
                    if (a_cnt + ONE == len_r) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // zero activations push the remaining partial sums out
                inst_p0 = {mode_r, 2'b10};
                if (d_cnt == D_LAST) state_nxt = DONE;
            end
            DONE: begin
                inst_p0   = {mode_r, 2'b00};
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job parameters and beat counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_r <= 1'b0;
            len_r  <= '0;
            w_cnt  <= '0;
            a_cnt  <= '0;
            d_cnt  <= '0;
        end else if (state == IDLE && start) begin
            mode_r <= mode;
            len_r  <= act_len;
            w_cnt  <= '0;
            a_cnt  <= '0;
            d_cnt  <= '0;
        end else begin
            if (state == LOAD && w_valid) w_cnt <= w_cnt + ONE;
            if (state == EXEC && a_valid) a_cnt <= a_cnt + ONE;
            if (state == DRAIN)           d_cnt <= d_cnt + 1'b1;
        end
    end

    // Registered row drive and status; busy/done track the state being entered
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_w <= 3'b000;
            in_w0  <= '0;
            in_w1  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            inst_w <= inst_p0;
            in_w0  <= row_p0[bw-1:0];
            in_w1  <= row_p0[2*bw-1:bw];
            busy   <= (state_nxt != IDLE);
            done   <= (state_nxt == DONE);
        end
    end

`ifdef MAC_ROW_CTRL_STATS_EN
    // Cycles spent waiting for a beat while a stream is open
    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= 16'd0;
        else if (state == IDLE && start)
            stall_cnt <= 16'd0;
        else if ((state == LOAD || state == EXEC) && !beat_acc)
            stall_cnt <= sat_inc16(stall_cnt);
    end
`endif

endmodule

// File: doc/mac_row_ctrl.md
# mac_row_ctrl

Sequencer that drives one `mac_row` (col columns, 2-bit activation halves `in_w0`/`in_w1`, 3-bit `inst_w` = {mode, exec, weightload}). On a start command it accepts weight beats over a valid/ready stream and issues them as weight-load instructions, then streams a programmed number of activation beats as execute instructions. It then flushes the row pipeline and pulses done. It sits between the tile-level scheduler/buffers and the `mac_row` instance.

## Interface
- `bw`, 2, activation half-width; `in_w0`/`in_w1` width.
- `col`, 4, number of MAC columns in the driven row.
- `len_bw`, 8, width of activation-count field.
- `clk` input 1, rising-edge clock.
- `reset` input 1, synchronous, active-low reset (asserted at 0).
- `start` input 1, begin a job; sampled only in IDLE.
- `mode` input 1, 0 = 2-bit weight mode, 1 = 4-bit weight mode; latched at start.
- `act_len` input len_bw, number of activation beats for the job; latched at start.
- `w_data` input 2*bw, weight beat, {hi, lo}.
- `w_valid` input 1 / `w_ready` output 1, weight stream handshake.
- `a_data` input 2*bw, activation beat, {hi, lo}.
- `a_valid` input 1 / `a_ready` output 1, activation stream handshake.
- `in_w0` output bw, to `mac_row.in_w0` (low half).
- `in_w1` output bw, to `mac_row.in_w1` (high half).
- `inst_w` output 3, to `mac_row.inst_w`.
- `busy` output 1, high in any state other than IDLE.
- `done` output 1, one-cycle pulse at job end.
- `stall_cnt` output 16, present only with MAC_ROW_CTRL_STATS_EN.

## Operation
- States: IDLE, LOAD, EXEC, DRAIN, DONE.
- IDLE: `start`=1 → latch mode and act_len, clear counters, go to LOAD. `start` in any other state is ignored.
- LOAD: `w_ready`=1. Weight target is 2*col beats for mode 0 and col beats for mode 1.
  - Accepted beat (w_valid & w_ready): next cycle drive inst_w={mode,0,1}, {in_w1,in_w0}=w_data, and increment the weight count.
  - No beat: next cycle drive inst_w={mode,0,0} with in_w=0 (bubble).
  - The accept that reaches the target moves to EXEC, or to DRAIN if act_len=0.
- EXEC: `a_ready`=1.
  - Accepted beat: next cycle drive inst_w={mode,1,0}, {in_w1,in_w0}=a_data, and increment the activation count.
  - No beat: bubble {mode,0,0} with in_w=0.
  - The accept that reaches act_len moves to DRAIN.
- DRAIN: exactly col cycles driving inst_w={mode,1,0} with in_w=0 (zero activations flush psums), then DONE.
- DONE: `done`=1 for one cycle, inst_w={mode,0,0}, then IDLE.
- `w_ready` and `a_ready` are decoded from state only, with no dependence on valid. Beats on the inactive stream are never consumed.
- Counters are len_bw wide. act_len = 2^len_bw − 1 is the maximum; there is no wrap within a job.

## Timing
- Reset (reset=0 at a rising edge) forces: IDLE, inst_w=0, in_w0=0, in_w1=0, w_ready=0, a_ready=0, busy=0, done=0, stall_cnt=0. Reset mid-job aborts the job immediately, with no done pulse and no drain.
- `inst_w`, `in_w0`, `in_w1`, `busy` and `done` are registered. The beat accepted at edge k appears on the row outputs after edge k, i.e. for cycle k+1.
- `start` at edge k: busy=1 and w_ready=1 from cycle k+1.
- Minimum job length with no stalls: 1 (start) + W + act_len + col + 1 (DONE) cycles, where W = 2*col or col.
- The last weight accept and the first activation accept occur on consecutive edges at earliest. No idle cycle is inserted between LOAD and EXEC.
- `done` and `busy` fall together. The next `start` is accepted in the cycle after DONE.

## Configuration
- `MAC_ROW_CTRL_STATS_EN` defined:
  - `stall_cnt` port exists.
  - It counts cycles in LOAD or EXEC with no accepted beat.
  - It saturates at 16'hFFFF and is cleared on reset and on start.
- `MAC_ROW_CTRL_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Mode 0, col=4, 8 back-to-back weights 1,2,3,4,8,0,9,7, act_len=16 with activations 0..15 → inst_w=001 for 8 cycles, then 010 for 16 cycles carrying 0..15, 4 drain cycles, done pulse; total 30 cycles from start.
- Mode 1, weights 1,−2,7,−8 with w_valid low every other cycle → 4 weight beats interleaved with bubbles inst_w=100, then EXEC at 110; stall_cnt=3 with the macro defined.
- act_len=0, mode 1 → LOAD of 4 beats, then direct to 4 drain cycles, then done; a_ready never asserts.
- Reset driven low in the 5th EXEC cycle → next cycle all outputs zero, state IDLE, no done; a fresh start afterwards runs a full job correctly.
- start held high for the whole job → exactly one job executes; a second job starts only on the start sampled in IDLE after DONE.
- a_valid high during LOAD and w_valid high during EXEC → neither beat consumed (a_ready=0 and w_ready=0 respectively); beat counts unchanged.
